// File: rtl/ssp_pkg.sv
// Shared types and widths for the SSP transmit controller.
package ssp_pkg;

  localparam int SSP_DATA_W = 8;
  localparam int SSP_DIV_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2,
    TAIL  = 2'd3
  } ssp_tx_state_t;

endpackage

// File: rtl/ssp_clk_div.sv
// Free-running SSPCLKOUT generator; rise_tick marks the PCLK edge where SSPCLKOUT rises.
module ssp_clk_div
  import ssp_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic PCLK,
  input  logic CLEAR,
  output logic SSPCLKOUT,
  output logic rise_tick
);

  localparam logic [SSP_DIV_W-1:0] DIV_TC = SSP_DIV_W'(CLK_DIV - 1);

  logic [SSP_DIV_W-1:0] div_cnt;
  logic                 wrap;

  assign wrap      = (div_cnt == DIV_TC);
  assign rise_tick = wrap && !SSPCLKOUT;

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      div_cnt   <= '0;
      SSPCLKOUT <= 1'b0;
    end else if (wrap) begin
      div_cnt   <= '0;
      SSPCLKOUT <= ~SSPCLKOUT;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit controller: pops bytes from the TX FIFO and sends TI-style frames MSB first.
// Build option SSP_TX_B2B_EN: chain the next byte onto the LSB period without TAIL/SYNC.
//
//   state | meaning
//   IDLE  | waiting for a byte; pops as soon as the FIFO is non-empty
//   SYNC  | byte loaded; next SSPCLKOUT rise drives the FSS pulse
//   SHIFT | driving data bits MSB first, one per SSPCLKOUT rise
//   TAIL  | LSB on the pins; next rise releases SSPOE_B and returns to IDLE
module ssp_tx_ctrl
  import ssp_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  PCLK,
  input  logic                  CLEAR,
  input  logic                  EMPTY,
  input  logic [SSP_DATA_W-1:0] TxDATA,
  output logic                  LOGICWRITE,
  output logic                  SSPCLKOUT,
  output logic                  SSPFSSOUT,
  output logic                  SSPTXD,
  output logic                  SSPOE_B,
  output logic                  BUSY
);

  localparam logic [2:0] LAST_BIT = 3'(SSP_DATA_W - 1);

  ssp_tx_state_t         state, state_nxt;
  logic [SSP_DATA_W-1:0] sr, sr_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic                  txd_nxt, fss_nxt, oe_b_nxt;
  logic                  pop;
  logic                  rise_tick;

  ssp_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .PCLK      (PCLK),
    .CLEAR     (CLEAR),
    .SSPCLKOUT (SSPCLKOUT),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      SSPTXD    <= 1'b0;
      SSPFSSOUT <= 1'b0;
      SSPOE_B   <= 1'b1;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      SSPTXD    <= txd_nxt;
      SSPFSSOUT <= fss_nxt;
      SSPOE_B   <= oe_b_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    txd_nxt     = SSPTXD;
    fss_nxt     = SSPFSSOUT;
    oe_b_nxt    = SSPOE_B;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY) begin
          pop       = 1'b1;
          sr_nxt    = TxDATA;
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (rise_tick) begin
          fss_nxt     = 1'b1;
          oe_b_nxt    = 1'b0;
          txd_nxt     = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_tick) begin
          txd_nxt     = sr[SSP_DATA_W-1];
          sr_nxt      = {sr[SSP_DATA_W-2:0], 1'b0};
          fss_nxt     = 1'b0;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
`ifdef SSP_TX_B2B_EN
            // Next byte's FSS shares the period of this byte's LSB.
            if (!EMPTY) begin
              pop         = 1'b1;
              sr_nxt      = TxDATA;
              fss_nxt     = 1'b1;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt   = TAIL;
            end
`else
            state_nxt = TAIL;
`endif
          end
        end
      end
      TAIL: begin
        if (rise_tick) begin
          oe_b_nxt  = 1'b1;
          txd_nxt   = 1'b0;
          fss_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign LOGICWRITE = pop && !CLEAR;
  assign BUSY       = (state != IDLE);

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Directed bench for ssp_tx_ctrl: two instances (CLK_DIV=1 and CLK_DIV=4), each fed by a small FIFO model.
module tb_ssp_tx_ctrl;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic       CLEAR;
  logic       empty1, empty4;
  logic [7:0] tx1, tx4;
  logic       lw1, clk1, fss1, txd1, oe1, busy1;
  logic       lw4, clk4, fss4, txd4, oe4, busy4;

  logic [7:0] fm1 [16];
  logic [7:0] fm4 [16];
  int wp1 = 0, rp1 = 0, wp4 = 0, rp4 = 0;

  assign empty1 = (wp1 == rp1);
  assign empty4 = (wp4 == rp4);
  assign tx1    = fm1[rp1[3:0]];
  assign tx4    = fm4[rp4[3:0]];

  always @(posedge PCLK) begin
    if (lw1 && !empty1) rp1 <= rp1 + 1;
    if (lw4 && !empty4) rp4 <= rp4 + 1;
  end

  ssp_tx_ctrl #(.CLK_DIV(1)) dut1 (
    .PCLK(PCLK), .CLEAR(CLEAR), .EMPTY(empty1), .TxDATA(tx1),
    .LOGICWRITE(lw1), .SSPCLKOUT(clk1), .SSPFSSOUT(fss1), .SSPTXD(txd1),
    .SSPOE_B(oe1), .BUSY(busy1)
  );

  ssp_tx_ctrl #(.CLK_DIV(4)) dut4 (
    .PCLK(PCLK), .CLEAR(CLEAR), .EMPTY(empty4), .TxDATA(tx4),
    .LOGICWRITE(lw4), .SSPCLKOUT(clk4), .SSPFSSOUT(fss4), .SSPTXD(txd4),
    .SSPOE_B(oe4), .BUSY(busy4)
  );

  int errors = 0;
  int checks = 0;

  logic c_clk [128], c_txd [128], c_fss [128], c_oe [128], c_lw [128], c_busy [128];
  int   ncap;

  int   n_lw, lw_at [16];
  int   n_bits, bit_at [32];
  logic bit_v [32];
  int   n_fssr, fssr_at [16];
  int   n_oer, oer_at [16];
  int   n_oef, oef_at [16];
  int   n_busyf, busyf_at [16];
  int   out_bad, clk_bad, fss_high;

  task automatic push1(input logic [7:0] b);
    fm1[wp1[3:0]] = b;
    wp1++;
  endtask

  task automatic push4(input logic [7:0] b);
    fm4[wp4[3:0]] = b;
    wp4++;
  endtask

  // Starts at a negedge; one sample per PCLK cycle, 1 time unit after the negedge.
  task automatic capture(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      if (which == 1) begin
        c_clk[k] = clk1; c_txd[k] = txd1; c_fss[k] = fss1;
        c_oe[k]  = oe1;  c_lw[k]  = lw1;  c_busy[k] = busy1;
      end else begin
        c_clk[k] = clk4; c_txd[k] = txd4; c_fss[k] = fss4;
        c_oe[k]  = oe4;  c_lw[k]  = lw4;  c_busy[k] = busy4;
      end
      @(negedge PCLK);
    end
    ncap = n;
  endtask

  // Data bits are the SSPCLKOUT rises where SSPOE_B was already low (excludes the SYNC rise).
  task automatic analyze(input int half);
    int last_chg;
    logic rise;
    n_lw = 0; n_bits = 0; n_fssr = 0; n_oer = 0; n_oef = 0; n_busyf = 0;
    out_bad = 0; clk_bad = 0; fss_high = 0; last_chg = -1;
    for (int k = 0; k < ncap; k++) begin
      if (c_lw[k] === 1'b1 && n_lw < 16) begin lw_at[n_lw] = k; n_lw++; end
      if (c_fss[k] === 1'b1) fss_high++;
      if (k > 0) begin
        rise = (c_clk[k] === 1'b1) && (c_clk[k-1] === 1'b0);
        if (c_clk[k] !== c_clk[k-1]) begin
          if (last_chg >= 0 && (k - last_chg) != half) clk_bad++;
          last_chg = k;
        end
        if (!rise && ((c_txd[k] !== c_txd[k-1]) || (c_fss[k] !== c_fss[k-1]) ||
                      (c_oe[k] !== c_oe[k-1]))) out_bad++;
        if (rise && c_oe[k] === 1'b0 && c_oe[k-1] === 1'b0 && n_bits < 32) begin
          bit_at[n_bits] = k; bit_v[n_bits] = c_txd[k]; n_bits++;
        end
        if (c_fss[k] === 1'b1 && c_fss[k-1] === 1'b0 && n_fssr < 16) begin
          fssr_at[n_fssr] = k; n_fssr++;
        end
        if (c_oe[k] === 1'b1 && c_oe[k-1] === 1'b0 && n_oer < 16) begin
          oer_at[n_oer] = k; n_oer++;
        end
        if (c_oe[k] === 1'b0 && c_oe[k-1] === 1'b1 && n_oef < 16) begin
          oef_at[n_oef] = k; n_oef++;
        end
        if (c_busy[k] === 1'b0 && c_busy[k-1] === 1'b1 && n_busyf < 16) begin
          busyf_at[n_busyf] = k; n_busyf++;
        end
      end
    end
  endtask

  function automatic logic [15:0] bits_word();
    logic [15:0] w;
    w = '0;
    for (int j = 0; j < n_bits && j < 16; j++) w = {w[14:0], bit_v[j]};
    return w;
  endfunction

  task automatic test_reset();
    logic [5:0] got;
    CLEAR = 1'b1;
    push1(8'hFF);
    push4(8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      #1;
      got = {lw1, oe1, txd1, fss1, clk1, busy1};
      checks++;
      if (got !== 6'b010000) begin
        errors++;
        $display("FAIL reset_dut1 cycle %0d: {lw,oe_b,txd,fss,sclk,busy} got %b want 010000", i, got);
      end
      got = {lw4, oe4, txd4, fss4, clk4, busy4};
      checks++;
      if (got !== 6'b010000) begin
        errors++;
        $display("FAIL reset_dut4 cycle %0d: {lw,oe_b,txd,fss,sclk,busy} got %b want 010000", i, got);
      end
    end
    checks++;
    if (rp1 !== 0 || rp4 !== 0) begin
      errors++;
      $display("FAIL reset_pops: got rp1=%0d rp4=%0d want 0 0", rp1, rp4);
    end
    wp1 = rp1;
    wp4 = rp4;
    CLEAR = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_single_byte();
    int rs;
    rs = rp1;
    push1(8'hA5);
    capture(1, 30);
    analyze(1);
    checks++;
    if (n_lw != 1 || rp1 - rs != 1) begin
      errors++;
      $display("FAIL single_pops: got strobes=%0d pops=%0d want 1 1", n_lw, rp1 - rs);
    end
    checks++;
    if (n_bits != 8 || bits_word() !== 16'h00A5) begin
      errors++;
      $display("FAIL single_bits: got n=%0d word=%h want n=8 word=00a5", n_bits, bits_word());
    end
    checks++;
    if (fss_high != 2) begin
      errors++;
      $display("FAIL single_fss_width: got %0d want 2", fss_high);
    end
    checks++;
    if (n_oer != 1 || n_bits != 8 || oer_at[0] - bit_at[7] != 2) begin
      errors++;
      $display("FAIL single_tail: got oe_rises=%0d gap=%0d want 1 2", n_oer, oer_at[0] - bit_at[7]);
    end
    checks++;
    if (n_busyf != 1 || busyf_at[0] != oer_at[0] || c_busy[ncap-1] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got falls=%0d at %0d want 1 at %0d", n_busyf, busyf_at[0], oer_at[0]);
    end
    checks++;
    if (out_bad != 0) begin
      errors++;
      $display("FAIL single_out_timing: got %0d off-rise changes want 0", out_bad);
    end
  endtask

  task automatic test_back_to_back();
    int rs;
    rs = rp1;
    push1(8'h3C);
    push1(8'hC3);
    capture(1, 70);
    analyze(1);
    checks++;
    if (n_lw != 2 || rp1 - rs != 2) begin
      errors++;
      $display("FAIL b2b_pops: got strobes=%0d pops=%0d want 2 2", n_lw, rp1 - rs);
    end
    checks++;
    if (n_bits != 16 || bits_word() !== 16'h3CC3) begin
      errors++;
      $display("FAIL b2b_bits: got n=%0d word=%h want n=16 word=3cc3", n_bits, bits_word());
    end
    checks++;
    if (out_bad != 0) begin
      errors++;
      $display("FAIL b2b_out_timing: got %0d off-rise changes want 0", out_bad);
    end
    checks++;
    if (n_fssr != 2) begin
      errors++;
      $display("FAIL b2b_fss_count: got %0d want 2", n_fssr);
    end
`ifdef SSP_TX_B2B_EN
    checks++;
    if (n_oer != 1) begin
      errors++;
      $display("FAIL b2b_oe_contig: got oe_rises=%0d want 1", n_oer);
    end
    checks++;
    if (n_bits < 9 || c_fss[bit_at[7]] !== 1'b1 || fssr_at[1] != bit_at[7]) begin
      errors++;
      $display("FAIL b2b_fss_on_lsb: got fss=%b fss_rise=%0d want 1 at %0d", c_fss[bit_at[7]], fssr_at[1], bit_at[7]);
    end
    checks++;
    if (n_lw < 2 || lw_at[1] != bit_at[7] - 1 || bit_at[8] - bit_at[7] != 2) begin
      errors++;
      $display("FAIL b2b_second_pop: got lw_at=%0d next_bit_gap=%0d want %0d 2", lw_at[1], bit_at[8] - bit_at[7], bit_at[7] - 1);
    end
`else
    checks++;
    if (n_oer != 2) begin
      errors++;
      $display("FAIL nob2b_oe_gap: got oe_rises=%0d want 2", n_oer);
    end
    checks++;
    if (n_lw < 2 || c_busy[lw_at[1]] !== 1'b0) begin
      errors++;
      $display("FAIL nob2b_pop_from_idle: got busy=%b at second pop want 0", c_busy[lw_at[1]]);
    end
    checks++;
    if (n_bits < 8 || fssr_at[1] - bit_at[7] != 4) begin
      errors++;
      $display("FAIL nob2b_fss_gap: got %0d want 4", fssr_at[1] - bit_at[7]);
    end
`endif
  endtask

  task automatic test_divider();
    int rs, bad_period;
    rs = rp4;
    push4(8'h81);
    capture(4, 110);
    analyze(4);
    checks++;
    if (n_lw != 1 || rp4 - rs != 1) begin
      errors++;
      $display("FAIL div_pops: got strobes=%0d pops=%0d want 1 1", n_lw, rp4 - rs);
    end
    checks++;
    if (n_bits != 8 || bits_word() !== 16'h0081) begin
      errors++;
      $display("FAIL div_bits: got n=%0d word=%h want n=8 word=0081", n_bits, bits_word());
    end
    bad_period = 0;
    for (int j = 0; j + 1 < n_bits; j++)
      if (bit_at[j+1] - bit_at[j] != 8) bad_period++;
    checks++;
    if (bad_period != 0 || clk_bad != 0) begin
      errors++;
      $display("FAIL div_period: got bit_bad=%0d sclk_bad=%0d want 0 0", bad_period, clk_bad);
    end
    checks++;
    if (out_bad != 0) begin
      errors++;
      $display("FAIL div_out_timing: got %0d off-rise changes want 0", out_bad);
    end
    checks++;
    if (fss_high != 8) begin
      errors++;
      $display("FAIL div_fss_width: got %0d want 8", fss_high);
    end
    checks++;
    if (n_fssr != 1 || fssr_at[0] < 2 || fssr_at[0] > 10) begin
      errors++;
      $display("FAIL div_pop_to_fss: got sample %0d want 2..10", fssr_at[0]);
    end
    checks++;
    if (n_oer != 1 || n_bits != 8 || oer_at[0] - bit_at[7] != 8) begin
      errors++;
      $display("FAIL div_tail: got gap=%0d want 8", oer_at[0] - bit_at[7]);
    end
  endtask

  task automatic test_mid_frame_reset();
    int rs, nb;
    logic pc, po, hit;
    logic [5:0] got;
    rs = rp1;
    push1(8'hF0);
    nb = 0; hit = 1'b0; pc = clk1; po = oe1;
    for (int i = 0; i < 60 && !hit; i++) begin
      #1;
      if (clk1 && !pc && !oe1 && !po) nb++;
      pc = clk1; po = oe1;
      if (nb == 4) hit = 1'b1;
      else @(negedge PCLK);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach_bit3: got %0d bits want 4 within 60 cycles", nb);
    end
    CLEAR = 1'b1;
    push1(8'h5A);
    checks++;
    if (lw1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_lw_gated: got %b want 0", lw1);
    end
    @(negedge PCLK);
    #1;
    got = {lw1, oe1, txd1, fss1, clk1, busy1};
    checks++;
    if (got !== 6'b010000) begin
      errors++;
      $display("FAIL mid_idle_outputs: {lw,oe_b,txd,fss,sclk,busy} got %b want 010000", got);
    end
    checks++;
    if (rp1 - rs != 1) begin
      errors++;
      $display("FAIL mid_no_repop: got pops=%0d want 1", rp1 - rs);
    end
    CLEAR = 1'b0;
    capture(1, 30);
    analyze(1);
    checks++;
    if (n_lw != 1 || lw_at[0] != 0 || rp1 - rs != 2) begin
      errors++;
      $display("FAIL mid_restart_pop: got strobes=%0d first=%0d pops=%0d want 1 0 2", n_lw, lw_at[0], rp1 - rs);
    end
    checks++;
    if (n_fssr < 1 || n_oef < 1 || fssr_at[0] != oef_at[0]) begin
      errors++;
      $display("FAIL mid_restart_sync: got fss_rise=%0d oe_fall=%0d want equal", fssr_at[0], oef_at[0]);
    end
    checks++;
    if (n_bits != 8 || bits_word() !== 16'h005A) begin
      errors++;
      $display("FAIL mid_restart_bits: got n=%0d word=%h want n=8 word=005a", n_bits, bits_word());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      fm1[i] = 8'h00;
      fm4[i] = 8'h00;
    end
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_divider();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
